// File: rtl/flash_responder_if.sv
// NOR flash bus between the flash controller (master) and the device model (slave).
interface flash_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              NF_CE;
    logic              NF_OE;
    logic              NF_WE;
    logic              NF_RP;
    logic              NF_WP;
    logic              NF_BYTE;
    logic [ADDR_W-1:0] NF_A;
    logic [7:0]        NF_D_IN;
    logic [7:0]        NF_D_OUT;
    logic              NF_D_OE;
    logic              NF_STS;

    modport master (
        output NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_BYTE, NF_A, NF_D_IN,
        input  NF_D_OUT, NF_D_OE, NF_STS
    );

    modport slave (
        input  NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_BYTE, NF_A, NF_D_IN,
        output NF_D_OUT, NF_D_OE, NF_STS
    );
endinterface

// File: rtl/flash_responder.sv
// Parallel NOR flash device model: Intel-style command set over a small x8 array,
// with program/erase busy time reported on NF_STS.
module flash_responder #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned PROG_CYCLES  = 8,
    parameter int unsigned ERASE_CYCLES = 64
) (
    input  logic             CLK_50MHZ,
    input  logic             RST,
    flash_responder_if.slave bus
);
    localparam int unsigned DEPTH      = 1 << ADDR_W;
    localparam int unsigned MEM_W      = DEPTH * 8;
    localparam int unsigned MAX_CYCLES = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        READ_ARRAY,
        READ_STATUS,
        PROG_SETUP,
        ERASE_SETUP,
        BUSY
    } mode_t;

    mode_t             mode;
    mode_t             mode_nxt;

    // Array is stored inverted so that zero-initialised storage reads as erased (0xFF).
    logic [MEM_W-1:0]  mem_n;

    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic              op_erase;
    logic [ADDR_W-1:0] op_addr;
    logic [7:0]        op_data;
    logic              sr5;
    logic              sr4;
    logic              sr1;
    logic [7:0]        d_out;
    logic              d_oe;
    logic              sts;

    logic              wr_ev_c;
    logic              expire_c;
    logic              rd_c;
    logic [7:0]        status_c;
    logic              load_prog_c;
    logic              load_erase_c;
    logic              set_sr5_c;
    logic              set_sr4_c;
    logic              set_sr1_c;
    logic              clr_sr_c;
    logic              unused_byte;

    assign unused_byte  = bus.NF_BYTE;
    assign bus.NF_D_OUT = d_out;
    assign bus.NF_D_OE  = d_oe;
    assign bus.NF_STS   = sts;

    // Command mode register; NF_RP acts as a synchronous device reset.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            mode <= READ_ARRAY;
        end else if (!bus.NF_RP) begin
            mode <= READ_ARRAY;
        end else begin
            mode <= mode_nxt;
        end
    end

    // Next command mode from write events and busy expiry.
    always_comb begin
        mode_nxt = mode;
        case (mode)
            READ_ARRAY, READ_STATUS: begin
                if (wr_ev_c) begin
                    case (bus.NF_D_IN)
                        8'hFF:        mode_nxt = READ_ARRAY;
                        8'h70:        mode_nxt = READ_STATUS;
                        8'h50:        mode_nxt = mode;
                        8'h40, 8'h10: mode_nxt = PROG_SETUP;
                        8'h20:        mode_nxt = ERASE_SETUP;
                        default:      mode_nxt = READ_ARRAY;
                    endcase
                end
            end
            PROG_SETUP: begin
                if (wr_ev_c) begin
                    mode_nxt = bus.NF_WP ? BUSY : READ_STATUS;
                end
            end
            ERASE_SETUP: begin
                if (wr_ev_c) begin
                    mode_nxt = (bus.NF_D_IN == 8'hD0 && bus.NF_WP) ? BUSY : READ_STATUS;
                end
            end
            BUSY: begin
                if (expire_c) begin
                    mode_nxt = READ_STATUS;
                end
            end
            default: mode_nxt = READ_ARRAY;
        endcase
    end

    // Decoded strobes: write/read qualification, status byte and datapath controls.
    always_comb begin
        wr_ev_c      = !we_q && bus.NF_WE && !bus.NF_CE && bus.NF_RP;
        expire_c     = (mode == BUSY) && (cnt == CNT_W'(1)) && bus.NF_RP;
        rd_c         = !bus.NF_CE && !bus.NF_OE && bus.NF_WE && bus.NF_RP;
        status_c     = {(mode != BUSY), 1'b0, sr5, sr4, 2'b00, sr1, 1'b0};
        load_prog_c  = 1'b0;
        load_erase_c = 1'b0;
        set_sr5_c    = 1'b0;
        set_sr4_c    = 1'b0;
        set_sr1_c    = 1'b0;
        clr_sr_c     = 1'b0;
        if (wr_ev_c) begin
            case (mode)
                READ_ARRAY, READ_STATUS: begin
                    clr_sr_c = (bus.NF_D_IN == 8'h50);
                end
                PROG_SETUP: begin
                    if (bus.NF_WP) begin
                        load_prog_c = 1'b1;
                    end else begin
                        set_sr4_c = 1'b1;
                        set_sr1_c = 1'b1;
                    end
                end
                ERASE_SETUP: begin
                    if (bus.NF_D_IN != 8'hD0) begin
                        set_sr5_c = 1'b1;
                        set_sr4_c = 1'b1;
                    end else if (bus.NF_WP) begin
                        load_erase_c = 1'b1;
                    end else begin
                        set_sr5_c = 1'b1;
                        set_sr1_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobe history, busy counter, pending operation and error flags.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            we_q     <= 1'b1;
            cnt      <= '0;
            op_erase <= 1'b0;
            op_addr  <= '0;
            op_data  <= 8'hFF;
            sr5      <= 1'b0;
            sr4      <= 1'b0;
            sr1      <= 1'b0;
            sts      <= 1'b1;
        end else begin
            we_q <= bus.NF_WE;
            if (!bus.NF_RP) begin
                cnt <= '0;
                sr5 <= 1'b0;
                sr4 <= 1'b0;
                sr1 <= 1'b0;
                sts <= 1'b1;
            end else begin
                sts <= (mode_nxt != BUSY);
                if (load_prog_c) begin
                    cnt      <= CNT_W'(PROG_CYCLES);
                    op_erase <= 1'b0;
                    op_addr  <= bus.NF_A;
                    op_data  <= bus.NF_D_IN;
                end else if (load_erase_c) begin
                    cnt      <= CNT_W'(ERASE_CYCLES);
                    op_erase <= 1'b1;
                end else if (mode == BUSY && cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
                if (clr_sr_c) begin
                    sr5 <= 1'b0;
                    sr4 <= 1'b0;
                    sr1 <= 1'b0;
                end else begin
                    sr5 <= sr5 | set_sr5_c;
                    sr4 <= sr4 | set_sr4_c;
                    sr1 <= sr1 | set_sr1_c;
                end
            end
        end
    end

    // Array update only when a busy period completes, so an abort leaves the array untouched.
    always_ff @(posedge CLK_50MHZ) begin
        if (expire_c) begin
            if (op_erase) begin
                mem_n <= '0;
            end else begin
                mem_n[{op_addr, 3'b000} +: 8] <= mem_n[{op_addr, 3'b000} +: 8] | ~op_data;
            end
        end
    end

    // Registered read path; data holds its last value while not driving.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            d_out <= 8'h00;
            d_oe  <= 1'b0;
        end else if (!bus.NF_RP) begin
            d_out <= 8'h00;
            d_oe  <= 1'b0;
        end else begin
            d_oe <= rd_c;
            if (rd_c) begin
                d_out <= (mode == READ_ARRAY) ? ~mem_n[{bus.NF_A, 3'b000} +: 8] : status_c;
            end
        end
    end
endmodule

// File: tb/tb_flash_responder.sv
// Bench for the NOR flash device model: directed command scenarios plus randomized programs.
module tb_flash_responder;
    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned PROG_CYCLES  = 8;
    localparam int unsigned ERASE_CYCLES = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flash_responder_if #(.ADDR_W(ADDR_W)) bus ();

    flash_responder #(
        .ADDR_W(ADDR_W),
        .PROG_CYCLES(PROG_CYCLES),
        .ERASE_CYCLES(ERASE_CYCLES)
    ) dut (
        .CLK_50MHZ(clk),
        .RST(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] ref_mem [256];

    // Length of the most recent contiguous NF_STS-low stretch, in sampled cycles.
    int run_len  = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (bus.NF_STS === 1'b0) run_len++;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic idle_bus();
        bus.NF_CE = 1'b1; bus.NF_OE = 1'b1; bus.NF_WE = 1'b1; bus.NF_RP = 1'b1;
        bus.NF_WP = 1'b1; bus.NF_BYTE = 1'b0; bus.NF_A = '0; bus.NF_D_IN = '0;
    endtask

    // One CE-qualified WE pulse; returns on the negedge after the capturing edge.
    task automatic write_cmd(input logic [7:0] a, input logic [7:0] d);
        bus.NF_CE = 1'b0; bus.NF_OE = 1'b1; bus.NF_WE = 1'b0; bus.NF_A = a; bus.NF_D_IN = d;
        @(negedge clk); bus.NF_WE = 1'b1;
        @(negedge clk); bus.NF_CE = 1'b1;
    endtask

    task automatic read_addr(input logic [7:0] a, output logic [7:0] data, output logic oe);
        bus.NF_CE = 1'b0; bus.NF_OE = 1'b0; bus.NF_WE = 1'b1; bus.NF_A = a;
        @(negedge clk);
        data = bus.NF_D_OUT; oe = bus.NF_D_OE;
        bus.NF_CE = 1'b1; bus.NF_OE = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int n = 0;
        while (bus.NF_STS !== 1'b1 && n < budget) begin
            @(negedge clk); n++;
        end
        ok = (bus.NF_STS === 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        repeat (3) @(negedge clk);
        checks++; if (bus.NF_STS !== 1'b1) begin failures++; $display("FAIL reset_sts got=%b exp=1", bus.NF_STS); end
        checks++; if (bus.NF_D_OE !== 1'b0) begin failures++; $display("FAIL reset_doe got=%b exp=0", bus.NF_D_OE); end
        checks++; if (bus.NF_D_OUT !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.NF_D_OUT); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_array();
        bus.NF_CE = 1'b0; bus.NF_OE = 1'b0; bus.NF_WE = 1'b1; bus.NF_A = 8'h35;
        #1;
        checks++; if (bus.NF_D_OE !== 1'b0) begin failures++; $display("FAIL read_latency_early got=%b exp=0", bus.NF_D_OE); end
        @(negedge clk);
        checks++; if (bus.NF_D_OE !== 1'b1) begin failures++; $display("FAIL read_doe got=%b exp=1", bus.NF_D_OE); end
        checks++; if (bus.NF_D_OUT !== ref_mem[8'h35]) begin failures++; $display("FAIL read_erased got=%h exp=%h", bus.NF_D_OUT, ref_mem[8'h35]); end
        checks++; if (bus.NF_STS !== 1'b1) begin failures++; $display("FAIL read_sts got=%b exp=1", bus.NF_STS); end
        bus.NF_CE = 1'b1; bus.NF_OE = 1'b1;
    endtask

    task automatic test_program();
        logic [7:0] rd; logic oe; bit ok;
        last_run = 0;
        write_cmd(8'h00, 8'h40);
        write_cmd(8'h35, 8'hC9);
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== 8'h00 || oe !== 1'b1) begin failures++; $display("FAIL prog_busy_read got=%h/%b exp=00/1", rd, oe); end
        wait_ready(PROG_CYCLES + 4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL prog_timeout got=busy exp=ready"); end
        checks++; if (last_run != PROG_CYCLES) begin failures++; $display("FAIL prog_busy_len got=%0d exp=%0d", last_run, PROG_CYCLES); end
        ref_mem[8'h35] = ref_mem[8'h35] & 8'hC9;
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== 8'h80) begin failures++; $display("FAIL prog_status got=%h exp=80", rd); end
        write_cmd(8'h00, 8'hFF);
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== ref_mem[8'h35]) begin failures++; $display("FAIL prog_data got=%h exp=%h", rd, ref_mem[8'h35]); end
    endtask

    task automatic test_program_and();
        logic [7:0] rd; logic oe; bit ok;
        write_cmd(8'h00, 8'h10);
        write_cmd(8'h35, 8'h3C);
        wait_ready(PROG_CYCLES + 4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL and_timeout got=busy exp=ready"); end
        ref_mem[8'h35] = ref_mem[8'h35] & 8'h3C;
        write_cmd(8'h00, 8'hFF);
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== ref_mem[8'h35]) begin failures++; $display("FAIL and_data got=%h exp=%h", rd, ref_mem[8'h35]); end
    endtask

    task automatic test_erase();
        logic [7:0] rd; logic oe; bit ok;
        last_run = 0;
        write_cmd(8'h00, 8'h20);
        write_cmd(8'h00, 8'hD0);
        wait_ready(ERASE_CYCLES + 8, ok);
        checks++; if (!ok) begin failures++; $display("FAIL erase_timeout got=busy exp=ready"); end
        checks++; if (last_run != ERASE_CYCLES) begin failures++; $display("FAIL erase_busy_len got=%0d exp=%0d", last_run, ERASE_CYCLES); end
        foreach (ref_mem[i]) ref_mem[i] = 8'hFF;
        read_addr(8'h00, rd, oe);
        checks++; if (rd !== 8'h80) begin failures++; $display("FAIL erase_status got=%h exp=80", rd); end
        write_cmd(8'h00, 8'hFF);
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== ref_mem[8'h35]) begin failures++; $display("FAIL erase_data got=%h exp=%h", rd, ref_mem[8'h35]); end
        last_run = 0;
        write_cmd(8'h00, 8'h20);
        write_cmd(8'h00, 8'h55);
        read_addr(8'h00, rd, oe);
        checks++; if (rd !== 8'hB0) begin failures++; $display("FAIL erase_seq_err got=%h exp=B0", rd); end
        checks++; if (last_run != 0) begin failures++; $display("FAIL erase_seq_nobusy got=%0d exp=0", last_run); end
        write_cmd(8'h00, 8'h50);
        read_addr(8'h00, rd, oe);
        checks++; if (rd !== 8'h80) begin failures++; $display("FAIL clear_status got=%h exp=80", rd); end
    endtask

    task automatic test_write_protect();
        logic [7:0] rd; logic oe;
        last_run = 0;
        write_cmd(8'h00, 8'h40);
        bus.NF_WP = 1'b0;
        write_cmd(8'h35, 8'h12);
        bus.NF_WP = 1'b1;
        read_addr(8'h00, rd, oe);
        checks++; if (rd !== 8'h92) begin failures++; $display("FAIL wp_status got=%h exp=92", rd); end
        checks++; if (last_run != 0 || run_len != 0) begin failures++; $display("FAIL wp_nobusy got=%0d exp=0", last_run + run_len); end
        write_cmd(8'h00, 8'h50);
        write_cmd(8'h00, 8'hFF);
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== ref_mem[8'h35]) begin failures++; $display("FAIL wp_data got=%h exp=%h", rd, ref_mem[8'h35]); end
    endtask

    task automatic test_rp_abort();
        logic [7:0] rd; logic oe;
        write_cmd(8'h00, 8'h40);
        write_cmd(8'h35, 8'h00);
        repeat (2) @(negedge clk);
        bus.NF_RP = 1'b0;
        @(negedge clk);
        checks++; if (bus.NF_STS !== 1'b1) begin failures++; $display("FAIL rp_sts got=%b exp=1", bus.NF_STS); end
        checks++; if (bus.NF_D_OE !== 1'b0 || bus.NF_D_OUT !== 8'h00) begin failures++; $display("FAIL rp_outputs got=%b/%h exp=0/00", bus.NF_D_OE, bus.NF_D_OUT); end
        bus.NF_RP = 1'b1;
        repeat (PROG_CYCLES + 2) @(negedge clk);
        checks++; if (bus.NF_STS !== 1'b1) begin failures++; $display("FAIL rp_stays_ready got=%b exp=1", bus.NF_STS); end
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== ref_mem[8'h35]) begin failures++; $display("FAIL rp_data got=%h exp=%h", rd, ref_mem[8'h35]); end
    endtask

    task automatic test_rst_abort();
        logic [7:0] rd; logic oe; bit ok;
        write_cmd(8'h00, 8'h40); write_cmd(8'h35, 8'h5A); wait_ready(PROG_CYCLES + 4, ok);
        ref_mem[8'h35] = ref_mem[8'h35] & 8'h5A;
        write_cmd(8'h00, 8'h40); write_cmd(8'h80, 8'hA5); wait_ready(PROG_CYCLES + 4, ok);
        ref_mem[8'h80] = ref_mem[8'h80] & 8'hA5;
        write_cmd(8'h00, 8'hFF);
        write_cmd(8'h00, 8'h20);
        write_cmd(8'h00, 8'hD0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.NF_STS !== 1'b1 || bus.NF_D_OE !== 1'b0 || bus.NF_D_OUT !== 8'h00) begin
            failures++; $display("FAIL rst_outputs got=%b/%b/%h exp=1/0/00", bus.NF_STS, bus.NF_D_OE, bus.NF_D_OUT);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (ERASE_CYCLES + 4) @(negedge clk);
        checks++; if (bus.NF_STS !== 1'b1) begin failures++; $display("FAIL rst_stays_ready got=%b exp=1", bus.NF_STS); end
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== ref_mem[8'h35]) begin failures++; $display("FAIL rst_data35 got=%h exp=%h", rd, ref_mem[8'h35]); end
        read_addr(8'h80, rd, oe);
        checks++; if (rd !== ref_mem[8'h80]) begin failures++; $display("FAIL rst_data80 got=%h exp=%h", rd, ref_mem[8'h80]); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] rd; logic oe;
        bus.NF_CE = 1'b0; bus.NF_OE = 1'b0; bus.NF_WE = 1'b0; bus.NF_A = 8'h35; bus.NF_D_IN = 8'h70;
        @(negedge clk);
        checks++; if (bus.NF_D_OE !== 1'b0) begin failures++; $display("FAIL oe_we_low_doe got=%b exp=0", bus.NF_D_OE); end
        bus.NF_WE = 1'b1;
        @(negedge clk);
        bus.NF_CE = 1'b1; bus.NF_OE = 1'b1;
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== 8'h80) begin failures++; $display("FAIL oe_we_low_write got=%h exp=80", rd); end
        bus.NF_CE = 1'b1; bus.NF_WE = 1'b0; bus.NF_D_IN = 8'hFF;
        @(negedge clk); bus.NF_WE = 1'b1;
        @(negedge clk);
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== 8'h80) begin failures++; $display("FAIL ce_high_ignored got=%h exp=80", rd); end
        write_cmd(8'h00, 8'hFF);
        read_addr(8'h35, rd, oe);
        checks++; if (rd !== ref_mem[8'h35]) begin failures++; $display("FAIL back_to_array got=%h exp=%h", rd, ref_mem[8'h35]); end
    endtask

    task automatic test_random();
        logic [7:0] rd; logic oe; bit ok;
        logic [7:0] a, b, d, cmd, exp_sr;
        bit wp;
        for (int it = 0; it < 12; it++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            wp = ($urandom_range(0, 3) != 0);
            last_run = 0;
            write_cmd(8'h00, ($urandom_range(0, 1) != 0) ? 8'h40 : 8'h10);
            bus.NF_WP = wp;
            write_cmd(a, d);
            bus.NF_WP = 1'b1;
            if (wp) begin
                wait_ready(PROG_CYCLES + 4, ok);
                checks++; if (!ok || last_run != PROG_CYCLES) begin failures++; $display("FAIL rnd_busy it=%0d got=%0d exp=%0d", it, last_run, PROG_CYCLES); end
                ref_mem[a] = ref_mem[a] & d;
                exp_sr = 8'h80;
            end else begin
                checks++; if (last_run != 0 || run_len != 0) begin failures++; $display("FAIL rnd_wp_busy it=%0d got=%0d exp=0", it, last_run + run_len); end
                exp_sr = 8'h92;
            end
            read_addr(8'h00, rd, oe);
            checks++; if (rd !== exp_sr) begin failures++; $display("FAIL rnd_status it=%0d got=%h exp=%h", it, rd, exp_sr); end
            write_cmd(8'h00, 8'h50);
            do cmd = 8'($urandom_range(0, 255));
            while (cmd == 8'h70 || cmd == 8'h50 || cmd == 8'h40 || cmd == 8'h10 || cmd == 8'h20);
            write_cmd(8'h00, cmd);
            read_addr(a, rd, oe);
            checks++; if (rd !== ref_mem[a]) begin failures++; $display("FAIL rnd_data it=%0d addr=%h got=%h exp=%h", it, a, rd, ref_mem[a]); end
            read_addr(b, rd, oe);
            checks++; if (rd !== ref_mem[b]) begin failures++; $display("FAIL rnd_other it=%0d addr=%h got=%h exp=%h", it, b, rd, ref_mem[b]); end
        end
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 8'hFF;
        idle_bus();
        test_reset();
        test_read_array();
        test_program();
        test_program_and();
        test_erase();
        test_write_protect();
        test_rp_abort();
        test_rst_abort();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flash_responder.md
Name: flash_responder

Overview:
- Synthesizable parallel NOR flash device model: the device end of the NF_* bus driven by the flash controller.
- Responds to CE/OE/WE strobes and implements an Intel-style command set (read array, read status, clear status, byte program, block erase) over a 256x8 array.
- Models busy time on NF_STS so the controller and flash timer can be exercised in simulation and on the board without a real device.

Parameters:
- ADDR_W, 8, address width; array depth is 2**ADDR_W bytes.
- PROG_CYCLES, 8, clock cycles the device stays busy for a byte program (min 1).
- ERASE_CYCLES, 64, clock cycles the device stays busy for a block erase (min 1).

Ports:
- CLK_50MHZ  input  1  system clock.
- RST  input  1  reset; asynchronous, active-high.
- NF_CE  input  1  chip enable, active-low.
- NF_OE  input  1  output enable, active-low.
- NF_WE  input  1  write enable, active-low; a command or data byte is taken on its rising edge.
- NF_RP  input  1  device reset/power-down, active-low.
- NF_WP  input  1  write protect, active-low.
- NF_BYTE  input  1  byte mode select; ignored, device is always x8.
- NF_A  input  ADDR_W  address.
- NF_D_IN  input  8  data from controller.
- NF_D_OUT  output  8  data to controller.
- NF_D_OE  output  1  high when the device drives the data bus.
- NF_STS  output  1  1 = ready, 0 = busy.

Behaviour:
- Reset (RST high, or NF_RP sampled low):
  - mode = READ_ARRAY, status = 0x80, busy counter = 0.
  - NF_STS = 1, NF_D_OUT = 0x00, NF_D_OE = 0.
  - Array contents are not affected; power-up contents are all 0xFF.
  - NF_RP low during a program or erase aborts it: the target byte or block is left as it was before the operation started.
- Write strobe:
  - we_q holds NF_WE registered.
  - A write event occurs in a cycle where we_q = 0, NF_WE = 1, NF_CE = 0 and NF_RP = 1.
  - NF_A and NF_D_IN are captured in that same cycle.
- Status register bits:
  - SR7 = ready.
  - SR5 = erase/sequence error.
  - SR4 = program/sequence error.
  - SR1 = write-protect violation.
  - All other bits are 0.
- Command FSM, driven by write events:
  - READ_ARRAY / READ_STATUS, on a write event:
    - 0xFF -> READ_ARRAY.
    - 0x70 -> READ_STATUS.
    - 0x50 -> clear SR5, SR4, SR1; mode unchanged.
    - 0x40 or 0x10 -> PROG_SETUP.
    - 0x20 -> ERASE_SETUP.
    - Any other value -> READ_ARRAY.
  - PROG_SETUP, on a write event:
    - If NF_WP = 0: set SR4 and SR1 -> READ_STATUS.
    - Otherwise: array[A] <= array[A] & D (bits can only be cleared), load counter with PROG_CYCLES -> BUSY.
  - ERASE_SETUP, on a write event:
    - Data 0xD0 and NF_WP = 1: load counter with ERASE_CYCLES -> BUSY. The whole array is set to 0xFF when the counter expires.
    - Data 0xD0 and NF_WP = 0: set SR5 and SR1 -> READ_STATUS.
    - Any other data: set SR5 and SR4 -> READ_STATUS.
  - BUSY:
    - SR7 = 0 and NF_STS = 0; write events are ignored.
    - The counter decrements each cycle. At 1, the operation commits, SR7 = 1, NF_STS = 1 on the next cycle, mode -> READ_STATUS.
    - Busy duration is exactly PROG_CYCLES or ERASE_CYCLES cycles after the write event.
- Read path:
  - NF_D_OE = 1 in the cycle after NF_CE = 0, NF_OE = 0, NF_WE = 1 and NF_RP = 1 are all sampled (1-cycle registered latency); 0 otherwise.
  - NF_D_OUT is registered one cycle after NF_A: array[NF_A] in READ_ARRAY, status register in every other mode, including BUSY and the setup states.
  - NF_D_OUT holds its last value while NF_D_OE = 0.
- Simultaneous events:
  - RST or NF_RP low overrides everything.
  - NF_OE and NF_WE both low: no read is driven (NF_D_OE = 0); the write is still taken on the NF_WE rising edge.
  - A write event with NF_CE high is ignored.

Test Plan:
- Reset, then read address 0x35 with CE = OE = 0 -> NF_D_OE = 1 one cycle later, NF_D_OUT = 0xFF, NF_STS = 1.
- Write 0x40 then data 0xC9 to address 0x35 -> NF_STS low for exactly 8 cycles; reads during busy return 0x00; afterwards status reads 0x80; after command 0xFF, address 0x35 reads 0xC9.
- Program 0x3C over existing 0xC9 at address 0x35 -> address 0x35 reads 0x08 (AND behaviour).
- Write 0x20 then 0xD0 -> busy for 64 cycles, then address 0x35 reads 0xFF. Repeat with 0x20 then 0x55 -> status reads 0xB0; after command 0x50, status reads 0x80.
- NF_WP = 0 during 0x40 then 0x12 -> status reads 0x92, array unchanged, NF_STS never goes low.
- Pulse NF_RP low 3 cycles into a program busy period -> NF_STS = 1 immediately, mode READ_ARRAY, target byte unchanged. Repeat with RST asserted mid-erase -> same recovery, array unchanged.
